prng_arbiter: RTL

PRNG_ARBITER -- requirements
Module: prng_arbiter

---
 rtl/prng_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/prng_arbiter.sv
// Round-robin front end that lets N_REQ requesters share one pseudo-random
// generator. One transaction at a time: grant, start pulse, wait for the
// generator busy window, then a one-cycle ack with the result or a timeout.
module prng_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] seed,
    input  logic [N_REQ*WIDTH-1:0] seq,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       rsp_num,
    output logic                   rsp_err,
    output logic                   prng_start,
    output logic [WIDTH-1:0]       prng_sw,
    output logic [WIDTH-1:0]       prng_seq,
    input  logic                   prng_busy,
    input  logic [WIDTH-1:0]       prng_num,
    output logic                   arb_busy
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

    state_t state, state_nxt;

    logic [N_REQ-1:0][WIDTH-1:0] seed_v, seq_v;
    logic [IW-1:0]    ptr, win_q, grant_idx;
    logic             grant_vld;
    logic [WIDTH-1:0] seed_q, seq_q, res_q;
    logic             err_q;
    logic [CW-1:0]    cnt;
    logic             timed_out;
    logic             in_flight;

    // slice k of the packed buses sits at bits [k*WIDTH +: WIDTH]
    assign seed_v = seed;
    assign seq_v  = seq;

    assign timed_out = (cnt == CW'(TIMEOUT));
    assign in_flight = (state == ISSUE) || (state == WAIT_BUSY) || (state == WAIT_DONE);

    // round-robin pick: first active request at or after ptr, wrapping
    always_comb begin
        int p;
        p         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            p = int'(ptr) + i;
            if (p >= N_REQ) p = p - N_REQ;
            if (!grant_vld && req[p]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(p);
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state and transaction outputs
    always_comb begin
        state_nxt  = state;
        ack        = '0;
        rsp_num    = '0;
        rsp_err    = 1'b0;
        prng_start = 1'b0;
        prng_sw    = '0;
        prng_seq   = '0;
        arb_busy   = (state != IDLE);
        if (in_flight) begin
            // an all-zero seed would lock the LFSR, so force the LSB
            prng_sw  = (seed_q == '0) ? WIDTH'(1) : seed_q;
            prng_seq = seq_q;
        end
        case (state)
            IDLE:      if (grant_vld && !prng_busy) state_nxt = ISSUE;
            ISSUE: begin
                prng_start = 1'b1;
                state_nxt  = WAIT_BUSY;
            end
            WAIT_BUSY: if (prng_busy || timed_out) state_nxt = prng_busy ? WAIT_DONE : RESPOND;
            WAIT_DONE: if (!prng_busy) state_nxt = RESPOND;
            RESPOND: begin
                ack[win_q] = 1'b1;
                rsp_num    = res_q;
                rsp_err    = err_q;
                state_nxt  = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // grant capture, timeout counter and result latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            win_q  <= '0;
            seed_q <= '0;
            seq_q  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (grant_vld && !prng_busy) begin
                    win_q  <= grant_idx;
                    seed_q <= seed_v[grant_idx];
                    seq_q  <= seq_v[grant_idx];
                    ptr    <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
                ISSUE: cnt <= '0;
                WAIT_BUSY: if (!prng_busy) begin
                    if (timed_out) begin
                        err_q <= 1'b1;
                        res_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: if (!prng_busy) begin
                    res_q <= prng_num;
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
